// File: rtl/fcpu_pkg.sv
// Shared CPU-wide widths and the common data bus payload type.
// Every unit that produces or consumes a CDB broadcast imports these
// definitions, so changing a width here resizes the whole bus.
package fcpu_pkg;

    localparam int RSV_ID_W = 6;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    // One CDB broadcast: destination ROB entry tag in the upper bits, result below
    typedef struct packed {
        logic [RSV_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   data;
    } cdb_t;

    // Width of an index into n items, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one active request, searching upward from
// the position just after the previous winner and wrapping at N.
// Purely combinational so it can also serve issue-port arbitration.
module rr_arbiter
    import fcpu_pkg::*;
#(
    parameter int N = 4,
    localparam int LW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant
);

    // Walk the requesters starting at last+1 and take the first active one
    always_comb begin
        logic          found;
        logic [LW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = LW'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each functional unit parks one finished result
// in its own holding buffer; one buffer per cycle is broadcast, chosen
// round-robin. Flush discards every parked result.
// Optional macro CDB_ARB_OUTREG_EN registers cdb_valid/cdb for timing,
// adding one cycle of latency.
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*CDB_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   flush,
    output logic                   cdb_valid,
    output logic [CDB_W-1:0]       cdb,
    output logic [N_REQ-1:0]       pending
);

    localparam int LW = idx_w(N_REQ);

    logic [N_REQ-1:0] full;
    cdb_t             hold_q [N_REQ];
    logic [LW-1:0]    last_grant;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] accept;
    logic [LW-1:0]    grant_idx;
    logic             bcast_valid;
    cdb_t             bcast;

    // Nothing competes for the bus while flushing or in reset
    assign arb_req = (flush || nrst) ? '0 : full;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (arb_req),
        .last  (last_grant),
        .grant (grant)
    );

    // A buffer being drained this cycle can take a new result at the same edge
    assign req_ready = (flush || nrst) ? '0 : (~full | grant);
    assign accept    = req_valid & req_ready;
    assign pending   = full;

    // Encode the one-hot grant and select the winning payload
    always_comb begin
        grant_idx = '0;
        bcast     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = LW'(i);
                bcast     = bcast | hold_q[i];
            end
        end
        bcast_valid = |grant;
    end

    // Buffer occupancy and round-robin pointer; a refill beats a drain
    always_ff @(posedge clk) begin
        if (nrst) begin
            full       <= '0;
            last_grant <= LW'(N_REQ - 1);
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (flush)
                    full[i] <= 1'b0;
                else if (accept[i])
                    full[i] <= 1'b1;
                else if (grant[i])
                    full[i] <= 1'b0;
            end
            if (|grant)
                last_grant <= grant_idx;
        end
    end

    // Payload capture; registers only move on an accept
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i])
                hold_q[i] <= cdb_t'(req_data[i*CDB_W +: CDB_W]);
        end
    end

`ifdef CDB_ARB_OUTREG_EN
    logic             cdb_valid_q;
    logic [CDB_W-1:0] cdb_q;

    // Output stage so the broadcast leaves from a flop; flush empties it too
    always_ff @(posedge clk) begin
        if (nrst || flush) begin
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
        end else begin
            cdb_valid_q <= bcast_valid;
            cdb_q       <= bcast;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb       = cdb_q;
`else
    assign cdb_valid = bcast_valid;
    assign cdb       = bcast;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with four requesters.
// Expected CDB values are written in terms of the grant cycle and delayed
// by one extra cycle when CDB_ARB_OUTREG_EN is defined.
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                nrst;
    logic [N-1:0]        req_valid;
    logic [N*CDB_W-1:0]  req_data;
    logic [N-1:0]        req_ready;
    logic                flush;
    logic                cdb_valid;
    logic [CDB_W-1:0]    cdb;
    logic [N-1:0]        pending;

    logic [CDB_W-1:0]    din [N];
    int                  n_tests = 0;
    int                  n_fail  = 0;
    logic                prev_v  = 1'b0;
    logic [CDB_W-1:0]    prev_d  = '0;

    cdb_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb       (cdb),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [CDB_W-1:0] mk(input int id, input int d);
        return {id[RSV_ID_W-1:0], d[DATA_W-1:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ev/ed describe what the arbiter grants this cycle
    task automatic checkCdb(input string tag, input logic ev, input logic [CDB_W-1:0] ed);
`ifdef CDB_ARB_OUTREG_EN
        checkOutput({tag, "_valid"}, 64'(cdb_valid), 64'(prev_v));
        checkOutput({tag, "_cdb"},   64'(cdb),       64'(prev_d));
        prev_v = ev;
        prev_d = ed;
`else
        checkOutput({tag, "_valid"}, 64'(cdb_valid), 64'(ev));
        checkOutput({tag, "_cdb"},   64'(cdb),       64'(ed));
`endif
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic fl);
        req_valid = v;
        flush     = fl;
        for (int i = 0; i < N; i++)
            req_data[i*CDB_W +: CDB_W] = din[i];
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        nrst = 1'b1;
        for (int i = 0; i < N; i++) din[i] = '0;
        applyStimulus('0, 1'b0);
        checkOutput("rst_ready", 64'(req_ready), 64'h0);
        tick();
        tick();
        nrst   = 1'b0;
        prev_v = 1'b0;
        prev_d = '0;
        applyStimulus('0, 1'b0);
    endtask

    initial begin
        nrst      = 1'b1;
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
        for (int i = 0; i < N; i++) din[i] = '0;
        tick();

        // Reset state
        applyReset();
        checkOutput("rst_valid",   64'(cdb_valid), 64'h0);
        checkOutput("rst_cdb",     64'(cdb),       64'h0);
        checkOutput("rst_pending", 64'(pending),   64'h0);
        checkOutput("rst_ready1",  64'(req_ready), 64'hF);

        // Single requester 2 sends {5, DEAD}
        din[2] = mk(5, 32'hDEAD);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("single_ready", 64'(req_ready), 64'hF);
        checkCdb("single_t0", 1'b0, '0);
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("single_pend1", 64'(pending), 64'h4);
        checkCdb("single_t1", 1'b1, mk(5, 32'hDEAD));
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("single_pend2", 64'(pending), 64'h0);
        checkCdb("single_t2", 1'b0, '0);
        tick();
        applyStimulus('0, 1'b0);
        checkCdb("single_t3", 1'b0, '0);

        // Fairness: all requesters valid continuously from reset
        applyReset();
        for (int c = 0; c <= 12; c++) begin
            logic [N-1:0] er;
            for (int i = 0; i < N; i++) din[i] = mk(i, c);
            applyStimulus(4'hF, 1'b0);
            er = (c == 0) ? 4'hF : (4'b0001 << ((c - 1) % 4));
            checkOutput($sformatf("fair_ready_c%0d", c), 64'(req_ready), 64'(er));
            if (c == 0)
                checkCdb($sformatf("fair_c%0d", c), 1'b0, '0);
            else
                checkCdb($sformatf("fair_c%0d", c), 1'b1, mk((c - 1) % 4, (c <= 4) ? 0 : c - 4));
            tick();
        end

        // Refill: requester 1 drained and refilled at the same edge
        applyReset();
        din[1] = mk(1, 32'hA);
        applyStimulus(4'b0010, 1'b0);
        checkCdb("refill_t0", 1'b0, '0);
        tick();
        din[1] = mk(1, 32'hB);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("refill_ready", 64'(req_ready), 64'hF);
        checkCdb("refill_t1", 1'b1, mk(1, 32'hA));
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("refill_pend", 64'(pending), 64'h2);
        checkCdb("refill_t2", 1'b1, mk(1, 32'hB));
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("refill_empty", 64'(pending), 64'h0);
        checkCdb("refill_t3", 1'b0, '0);

        // Flush with buffers 0 and 3 full; result offered during flush is dropped
        applyReset();
        din[0] = mk(0, 32'h11);
        din[3] = mk(3, 32'h33);
        applyStimulus(4'b1001, 1'b0);
        checkCdb("flush_t0", 1'b0, '0);
        tick();
        din[2] = mk(2, 32'h22);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("flush_pend_full", 64'(pending),   64'h9);
        checkOutput("flush_ready",     64'(req_ready), 64'h0);
        checkCdb("flush_t1", 1'b0, '0);
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("flush_pend_clr", 64'(pending), 64'h0);
        checkCdb("flush_t2", 1'b0, '0);
        tick();
        applyStimulus('0, 1'b0);
        checkCdb("flush_t3", 1'b0, '0);

        // Wrap: requester 3 wins first, then 3 and 0 compete -> 0 before 3
        applyReset();
        din[3] = mk(3, 32'hA3);
        applyStimulus(4'b1000, 1'b0);
        checkCdb("wrap_t0", 1'b0, '0);
        tick();
        din[0] = mk(0, 32'hB0);
        din[3] = mk(3, 32'hC3);
        applyStimulus(4'b1001, 1'b0);
        checkCdb("wrap_t1", 1'b1, mk(3, 32'hA3));
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("wrap_pend", 64'(pending), 64'h9);
        checkCdb("wrap_t2", 1'b1, mk(0, 32'hB0));
        tick();
        applyStimulus('0, 1'b0);
        checkCdb("wrap_t3", 1'b1, mk(3, 32'hC3));
        tick();
        applyStimulus('0, 1'b0);
        checkCdb("wrap_t4", 1'b0, '0);
        tick();
        applyStimulus('0, 1'b0);
        checkCdb("wrap_t5", 1'b0, '0);

        // Reset mid-burst: parked results are lost quietly
        applyReset();
        for (int i = 0; i < N; i++) din[i] = mk(i, 32'h50 + i);
        applyStimulus(4'hF, 1'b0);
        checkCdb("midrst_t0", 1'b0, '0);
        tick();
        nrst = 1'b1;
        applyStimulus(4'hF, 1'b0);
        checkOutput("midrst_ready", 64'(req_ready), 64'h0);
        tick();
        nrst = 1'b0;
        applyStimulus('0, 1'b0);
        checkOutput("midrst_pend",  64'(pending),   64'h0);
        checkOutput("midrst_valid", 64'(cdb_valid), 64'h0);
        checkOutput("midrst_cdb",   64'(cdb),       64'h0);
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("midrst_valid2", 64'(cdb_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
